fifo_rd_stream_adapter_1: RTL and testbench
===========================================

// Module: fifo_rd_stream_adapter_1
// PURPOSE
//  Read-side consumer for the FIFO read port (r_en / r_empty / rdata). rdata is
//  show-ahead: valid combinationally while r_empty=0, consumed by r_en in the same cycle.
//  Block pops words and presents them on a registered valid/ready stream through a
//  2-entry skid buffer. r_en never depends combinationally on out_ready. Sits in the
//  r_clk domain, between the FIFO and downstream logic.
// PARAMETERS
//  MEMORY_WIDTH  8   data width, matches FIFO rdata
//  CNT_WIDTH     16  width of delivered-word counter
// PORTS
//  r_clk      in   1             read-domain clock, all logic on posedge
//  rrst       in   1             synchronous, active-high reset
//  r_empty    in   1             FIFO empty flag
//  rdata      in   MEMORY_WIDTH  FIFO head word, valid when r_empty=0
//  r_en       out  1             pop strobe to FIFO (combinational)
//  flush      in   1             synchronous drop of all buffered words
//  out_ready  in   1             downstream accepts out_data this cycle
//  out_valid  out  1             out_data holds a word
//  out_data   out  MEMORY_WIDTH  stream data (registered)
//  out_level  out  2             words held: 0, 1 or 2
//  word_cnt   out  CNT_WIDTH     words delivered (fire count), wraps
// BEHAVIOUR
//  Reset (rrst=1 at posedge): state EMPTY, out_data=0, skid=0, word_cnt=0.
//    r_en=0 whenever rrst=1. out_valid=0 and out_level=0 follow from state.
//  State: EMPTY (level 0), ONE (out_data valid), TWO (out_data + skid valid).
//  out_valid = (state!=EMPTY). fire = out_valid & out_ready.
//  pop = r_en = !rrst & !flush & !r_empty & (state!=TWO). Never pop in TWO.
//  Transitions, on posedge:
//    EMPTY: pop -> ONE, out_data<=rdata; else stay.
//    ONE:   pop&fire  -> ONE, out_data<=rdata.
//           pop&!fire -> TWO, skid<=rdata.
//           !pop&fire -> EMPTY. Otherwise stay.
//    TWO:   fire -> ONE, out_data<=skid. Otherwise stay.
//  Latency: a word at the FIFO head while EMPTY is on out_data 1 cycle after pop.
//  Sustained throughput: 1 word/cycle while out_ready=1 and r_empty=0.
//  out_data holds stable while out_valid=1 and out_ready=0 (no overwrite, no loss).
//  word_cnt increments by 1 per fire and wraps modulo 2**CNT_WIDTH.
//  flush=1: next state EMPTY. Buffered words are dropped and not counted.
//    A fire in the same cycle is still counted. r_en=0 that cycle.
//  Priority: rrst > flush > normal operation.
//  r_empty rising in the same cycle as a pop: the pop is invalid by construction.
//    r_en requires r_empty=0.
//  Reset mid-burst: buffered words are lost. FIFO pointers are not touched by this block.
// TESTING
//  1 Reset: rrst=1 for 2 cycles, FIFO holds 3 words
//    -> r_en=0, out_valid=0, out_level=0, word_cnt=0.
//  2 Streaming: FIFO holds 0x11,0x22,0x33, out_ready=1
//    -> out_data 0x11,0x22,0x33 on 3 consecutive cycles, then out_valid=0; word_cnt=3.
//  3 Backpressure: out_ready=0, 4 words queued
//    -> exactly 2 pops, out_level=2, r_en=0 after.
//    Then out_ready=1 -> all 4 words delivered in order, none lost or duplicated.
//  4 Stall hold: out_ready toggles 1,0,0,1 with 0xA5 at the head
//    -> out_data holds 0xA5 while stalled, each word accepted exactly once.
//  5 Flush: out_level=2, flush=1 with out_ready=0
//    -> next cycle out_level=0, word_cnt unchanged, r_en=0 during flush.
//  6 Wrap: CNT_WIDTH=4, deliver 17 words -> word_cnt=1.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_1.sv
// fifo_rd_stream_adapter_1: pops a show-ahead FIFO read port into a registered valid/ready stream via a 2-entry skid buffer
module fifo_rd_stream_adapter_1 #(
   parameter int MEMORY_WIDTH = 8,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    r_clk,
   input  logic                    rrst,
   input  logic                    r_empty,
   input  logic [MEMORY_WIDTH-1:0] rdata,
   output logic                    r_en,
   input  logic                    flush,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [MEMORY_WIDTH-1:0] out_data,
   output logic [1:0]              out_level,
   output logic [CNT_WIDTH-1:0]    word_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t                  state, state_d;
   logic [MEMORY_WIDTH-1:0] skid;
   logic                    fire, pop, load_out, load_skid;
   assign out_valid = state != EMPTY;
   assign out_level = state;
   assign fire      = out_valid && out_ready;
   assign pop       = !rrst && !flush && !r_empty && state != TWO;
   assign r_en      = pop;
   // next-state and register-load decode; flush forces EMPTY and suppresses loads
   always_comb begin
      state_d   = flush ? EMPTY :
                  state == EMPTY ? (pop ? ONE : EMPTY) :
                  state == ONE   ? (pop && !fire ? TWO : !pop && fire ? EMPTY : ONE) :
                                   (fire ? ONE : TWO);
      load_out  = !flush && (state == TWO ? fire : pop && (state == EMPTY || fire));
      load_skid = !flush && state == ONE && pop && !fire;
   end
   // state, output/skid registers and delivered-word counter
   always_ff @(posedge r_clk) begin
      if (rrst) begin
         state    <= EMPTY;
         out_data <= '0;
         skid     <= '0;
         word_cnt <= '0;
      end else begin
         state <= state_d;
         if (load_out) out_data <= state == TWO ? skid : rdata;
         if (load_skid) skid <= rdata;
         if (fire) word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream_adapter_1.sv
// tb_fifo_rd_stream_adapter_1: directed scenarios against a small FIFO model and an output capture log
module tb_fifo_rd_stream_adapter_1;
   logic       r_clk = 1'b0;
   logic       rrst = 1'b1;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       r_empty, r_en, out_valid;
   logic [7:0] rdata, out_data;
   logic [1:0] out_level;
   logic [3:0] word_cnt;
   logic [7:0] mem [0:63];
   logic [7:0] rx [0:127];
   int         head = 0;
   int         tail = 0;
   int         rx_n = 0;
   int         total = 0;
   int         bad = 0;

   fifo_rd_stream_adapter_1 #(.MEMORY_WIDTH(8), .CNT_WIDTH(4)) dut (
      .r_clk(r_clk), .rrst(rrst), .r_empty(r_empty), .rdata(rdata), .r_en(r_en),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_level(out_level), .word_cnt(word_cnt)
   );

   always #5 r_clk = ~r_clk;

   assign r_empty = head == tail;
   assign rdata   = mem[head[5:0]];

   // FIFO head advance on pop and log of every accepted output word
   always @(posedge r_clk) begin
      if (r_en) head <= head + 1;
      if (out_valid && out_ready) begin
         rx[rx_n[6:0]] <= out_data;
         rx_n <= rx_n + 1;
      end
   end

   task automatic push(input logic [7:0] v);
      mem[tail[5:0]] = v;
      tail++;
   endtask

   task automatic test_reset;
      push(8'h01); push(8'h02); push(8'h03);
      @(negedge r_clk); @(negedge r_clk);
      total++; if (r_en !== 1'b0) begin bad++; $display("FAIL reset_r_en got=%b exp=0", r_en); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", out_level); end
      total++; if (word_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
      total++; if (head !== 0) begin bad++; $display("FAIL reset_pops got=%0d exp=0", head); end
      tail = head;
   endtask

   task automatic test_streaming;
      logic [7:0] exp_s [0:2];
      exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h33;
      rrst = 1'b0;
      out_ready = 1'b1;
      push(8'h11); push(8'h22); push(8'h33);
      for (int i = 0; i < 3; i++) begin
         @(negedge r_clk);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, out_valid); end
         total++; if (out_data !== exp_s[i]) begin bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, out_data, exp_s[i]); end
      end
      @(negedge r_clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
      total++; if (word_cnt !== 4'd3) begin bad++; $display("FAIL stream_cnt got=%0d exp=3", word_cnt); end
   endtask

   task automatic test_backpressure;
      int h0, r0;
      out_ready = 1'b0;
      h0 = head;
      push(8'h41); push(8'h42); push(8'h43); push(8'h44);
      repeat (5) @(negedge r_clk);
      total++; if (head - h0 !== 2) begin bad++; $display("FAIL bp_pops got=%0d exp=2", head - h0); end
      total++; if (out_level !== 2'd2) begin bad++; $display("FAIL bp_level got=%0d exp=2", out_level); end
      total++; if (r_en !== 1'b0) begin bad++; $display("FAIL bp_r_en got=%b exp=0", r_en); end
      total++; if (out_data !== 8'h41) begin bad++; $display("FAIL bp_head got=%h exp=41", out_data); end
      out_ready = 1'b1;
      r0 = rx_n;
      repeat (6) @(negedge r_clk);
      total++; if (rx_n - r0 !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", rx_n - r0); end
      for (int i = 0; i < 4; i++) begin
         total++; if (rx[r0 + i] !== 8'(8'h41 + i)) begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", i, rx[r0 + i], 8'(8'h41 + i)); end
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
      total++; if (word_cnt !== 4'd7) begin bad++; $display("FAIL bp_cnt got=%0d exp=7", word_cnt); end
   endtask

   task automatic test_stall;
      int r0;
      r0 = rx_n;
      out_ready = 1'b1;
      push(8'hA5);
      @(negedge r_clk);
      total++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_present got=%h/%b exp=a5/1", out_data, out_valid); end
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge r_clk);
         total++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%h/%b exp=a5/1", i, out_data, out_valid); end
         total++; if (rx_n !== r0) begin bad++; $display("FAIL stall_noaccept%0d got=%0d exp=%0d", i, rx_n, r0); end
      end
      out_ready = 1'b1;
      @(negedge r_clk);
      total++; if (rx_n !== r0 + 1) begin bad++; $display("FAIL stall_once got=%0d exp=%0d", rx_n - r0, 1); end
      total++; if (rx[r0] !== 8'hA5) begin bad++; $display("FAIL stall_word got=%h exp=a5", rx[r0]); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_end_valid got=%b exp=0", out_valid); end
      total++; if (word_cnt !== 4'd8) begin bad++; $display("FAIL stall_cnt got=%0d exp=8", word_cnt); end
   endtask

   task automatic test_flush;
      int r0;
      out_ready = 1'b0;
      push(8'h61); push(8'h62); push(8'h63);
      repeat (3) @(negedge r_clk);
      total++; if (out_level !== 2'd2) begin bad++; $display("FAIL flush_pre_level got=%0d exp=2", out_level); end
      flush = 1'b1;
      #1;
      total++; if (r_en !== 1'b0) begin bad++; $display("FAIL flush_r_en0 got=%b exp=0", r_en); end
      @(negedge r_clk);
      total++; if (out_level !== 2'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", out_level); end
      total++; if (word_cnt !== 4'd8) begin bad++; $display("FAIL flush_cnt got=%0d exp=8", word_cnt); end
      total++; if (r_en !== 1'b0) begin bad++; $display("FAIL flush_r_en1 got=%b exp=0", r_en); end
      flush = 1'b0;
      tail = head;
      push(8'h71);
      @(negedge r_clk);
      total++; if (out_level !== 2'd1) begin bad++; $display("FAIL flush_one_level got=%0d exp=1", out_level); end
      r0 = rx_n;
      out_ready = 1'b1;
      flush = 1'b1;
      @(negedge r_clk);
      total++; if (out_level !== 2'd0) begin bad++; $display("FAIL flushfire_level got=%0d exp=0", out_level); end
      total++; if (word_cnt !== 4'd9) begin bad++; $display("FAIL flushfire_cnt got=%0d exp=9", word_cnt); end
      total++; if (rx[r0] !== 8'h71) begin bad++; $display("FAIL flushfire_word got=%h exp=71", rx[r0]); end
      flush = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_wrap;
      int r0;
      rrst = 1'b1;
      @(negedge r_clk);
      total++; if (word_cnt !== 4'd0) begin bad++; $display("FAIL wrap_reset_cnt got=%0d exp=0", word_cnt); end
      rrst = 1'b0;
      out_ready = 1'b1;
      r0 = rx_n;
      for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
      repeat (22) @(negedge r_clk);
      total++; if (rx_n - r0 !== 17) begin bad++; $display("FAIL wrap_delivered got=%0d exp=17", rx_n - r0); end
      total++; if (rx[r0 + 16] !== 8'h90) begin bad++; $display("FAIL wrap_last got=%h exp=90", rx[r0 + 16]); end
      total++; if (word_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", word_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_end_valid got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset;
      test_streaming;
      test_backpressure;
      test_stall;
      test_flush;
      test_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
